// File: rtl/vector_datapath_pkg.sv
// Shared widths, types and controller state codes for the vector dot-product datapath.
package vector_datapath_pkg;

    localparam int W = 8;
    localparam int N = 10;

    typedef logic [W-1:0] word_t;

    // Gray-style sequence used by the external controller; carried here for debug decode only.
    typedef enum logic [3:0] {
        S1  = 4'b0000,
        S2  = 4'b0001,
        S3  = 4'b0011,
        S4  = 4'b0010,
        S5  = 4'b0110,
        S6  = 4'b0111,
        S7  = 4'b1111,
        S8  = 4'b1110,
        S9  = 4'b1010,
        S10 = 4'b1011,
        S11 = 4'b1001,
        S12 = 4'b1000
    } ctrl_state_t;

endpackage

// File: rtl/vector_datapath_pair_select.sv
// Picks the operand pair for one arithmetic unit: the registers at the lowest
// and second-lowest set bits of the enable vector.
module vector_datapath_pair_select
    import vector_datapath_pkg::*;
(
    input  logic [N-1:0] en,
    input  word_t        regs [N],
    output word_t        a,
    output word_t        b,
    output logic         valid
);

    logic got_a;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value unassigned (no latch).
        a     = '0;
        b     = '0;
        valid = 1'b0;
        got_a = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (en[i]) begin
                if (!got_a) begin
                    a     = regs[i];
                    got_a = 1'b1;
                end else if (!valid) begin
                    b     = regs[i];
                    valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vector_datapath.sv
// Ten-register datapath with one multiplier and two adders; all sequencing comes
// from the external controller through the per-register control vectors.
module vector_datapath
    import vector_datapath_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   state,
    input  logic [W-1:0] next_in,
    input  logic [N-1:0] load,
    input  logic [N-1:0] mul_en,
    input  logic [N-1:0] add1_en,
    input  logic [N-1:0] add2_en,
    input  logic [N-1:0] mul_read,
    input  logic [N-1:0] add1_read,
    input  logic [N-1:0] add2_read,
    output logic [W-1:0] r1,
    output logic [W-1:0] r2,
    output logic [W-1:0] r3,
    output logic [W-1:0] r4,
    output logic [W-1:0] r5,
    output logic [W-1:0] r6,
    output logic [W-1:0] r7,
    output logic [W-1:0] r8,
    output logic [W-1:0] r9,
    output logic [W-1:0] r10,
    output logic [W-1:0] f
);

    word_t regs [N];
    word_t mul_q, add1_q, add2_q;

    word_t mul_a, mul_b, add1_a, add1_b, add2_a, add2_b;
    logic  mul_v, add1_v, add2_v;

    // The controller state is informational; folded into a sink so it stays visible in netlists.
    logic unused_state;
    assign unused_state = ^state;

    vector_datapath_pair_select u_mul_sel (
        .en    (mul_en),
        .regs  (regs),
        .a     (mul_a),
        .b     (mul_b),
        .valid (mul_v)
    );

    vector_datapath_pair_select u_add1_sel (
        .en    (add1_en),
        .regs  (regs),
        .a     (add1_a),
        .b     (add1_b),
        .valid (add1_v)
    );

    vector_datapath_pair_select u_add2_sel (
        .en    (add2_en),
        .regs  (regs),
        .a     (add2_a),
        .b     (add2_b),
        .valid (add2_v)
    );

    // Results truncate to W bits: the product keeps its low byte, sums wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_q  <= '0;
            add1_q <= '0;
            add2_q <= '0;
        end else begin
            // NOTE: non-blocking so every unit and write-back sees the same pre-edge register values.
            if (mul_v)  mul_q  <= mul_a * mul_b;
            if (add1_v) add1_q <= add1_a + add1_b;
            if (add2_v) add2_q <= add2_a + add2_b;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the register file is small flops, not RAM, and must read zero straight out of reset.
            for (int i = 0; i < N; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (load[i])           regs[i] <= next_in;
                else if (mul_read[i])  regs[i] <= mul_q;
                else if (add1_read[i]) regs[i] <= add1_q;
                else if (add2_read[i]) regs[i] <= add2_q;
            end
        end
    end

    assign r1  = regs[0];
    assign r2  = regs[1];
    assign r3  = regs[2];
    assign r4  = regs[3];
    assign r5  = regs[4];
    assign r6  = regs[5];
    assign r7  = regs[6];
    assign r8  = regs[7];
    assign r9  = regs[8];
    assign r10 = regs[9];
    assign f   = add2_q;

endmodule

// File: tb/tb_vector_datapath.sv
// Directed step table for the documented scenarios, async reset checks, then
// randomized traffic against a queue-based reference model.
module tb_vector_datapath;
    import vector_datapath_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   state;
    logic [7:0]   next_in;
    logic [9:0]   load, mul_en, add1_en, add2_en, mul_read, add1_read, add2_read;
    logic [7:0]   r1, r2, r3, r4, r5, r6, r7, r8, r9, r10, f;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    vector_datapath dut (
        .clk       (clk),
        .reset     (reset),
        .state     (state),
        .next_in   (next_in),
        .load      (load),
        .mul_en    (mul_en),
        .add1_en   (add1_en),
        .add2_en   (add2_en),
        .mul_read  (mul_read),
        .add1_read (add1_read),
        .add2_read (add2_read),
        .r1        (r1),
        .r2        (r2),
        .r3        (r3),
        .r4        (r4),
        .r5        (r5),
        .r6        (r6),
        .r7        (r7),
        .r8        (r8),
        .r9        (r9),
        .r10       (r10),
        .f         (f)
    );

    // Observation index: 1..10 are r1..r10, 11 is f.
    function automatic logic [7:0] obs(input int k);
        case (k)
            1:  return r1;
            2:  return r2;
            3:  return r3;
            4:  return r4;
            5:  return r5;
            6:  return r6;
            7:  return r7;
            8:  return r8;
            9:  return r9;
            10: return r10;
            default: return f;
        endcase
    endfunction

    function automatic string obs_name(input int k);
        return (k == 11) ? "f" : $sformatf("r%0d", k);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] ni;
        logic [9:0] ld, me, a1e, a2e, mr, a1r, a2r;
        int         chk;
        logic [7:0] exp;
    } step_t;

    step_t steps[$];

    function automatic logic [9:0] rb(input int n);
        logic [9:0] one;
        one = 10'd1;
        return one << (n - 1);
    endfunction

    function automatic step_t mk(input logic [7:0] ni, input logic [9:0] ld, me, a1e, a2e,
                                 mr, a1r, a2r, input int chk, input logic [7:0] exp);
        step_t s;
        s.ni = ni; s.ld = ld; s.me = me; s.a1e = a1e; s.a2e = a2e;
        s.mr = mr; s.a1r = a1r; s.a2r = a2r; s.chk = chk; s.exp = exp;
        return s;
    endfunction

    task automatic drive(input logic [7:0] ni, input logic [9:0] ld, me, a1e, a2e, mr, a1r, a2r);
        @(negedge clk);
        state     = 4'($urandom);
        next_in   = ni;
        load      = ld;
        mul_en    = me;
        add1_en   = a1e;
        add2_en   = a2e;
        mul_read  = mr;
        add1_read = a1r;
        add2_read = a2r;
        @(posedge clk);
        #1;
    endtask

    // Reference model state: R1..R10 and the three unit results.
    int m_r [1:10];
    int m_mul, m_add1, m_add2;

    function automatic void pick(input logic [9:0] en, output bit v, output int a, output int b);
        int q[$];
        for (int i = 0; i < 10; i++) if (en[i]) q.push_back(m_r[i + 1]);
        v = (q.size() >= 2);
        a = v ? q[0] : 0;
        b = v ? q[1] : 0;
    endfunction

    function automatic void model_step(input logic [7:0] ni, input logic [9:0] ld, me, a1e, a2e,
                                       mr, a1r, a2r);
        int  nr [1:10];
        bit  v;
        int  a, b;
        for (int i = 1; i <= 10; i++) begin
            if (ld[i-1])       nr[i] = int'(ni);
            else if (mr[i-1])  nr[i] = m_mul;
            else if (a1r[i-1]) nr[i] = m_add1;
            else if (a2r[i-1]) nr[i] = m_add2;
            else               nr[i] = m_r[i];
        end
        pick(me, v, a, b);
        if (v) m_mul = (a * b) % 256;
        pick(a1e, v, a, b);
        if (v) m_add1 = (a + b) % 256;
        pick(a2e, v, a, b);
        if (v) m_add2 = (a + b) % 256;
        for (int i = 1; i <= 10; i++) m_r[i] = nr[i];
    endfunction

    function automatic logic [9:0] rnd_en();
        case ($urandom % 4)
            0:       return rb(int'($urandom % 10) + 1);
            1:       return 10'd0;
            default: return 10'($urandom);
        endcase
    endfunction

    function automatic logic [9:0] rnd_sparse();
        return 10'($urandom & $urandom & $urandom);
    endfunction

    initial begin
        logic [9:0] z;
        z = 10'd0;

        // Load phase, then pipelined multiplies with write-back and truncation.
        steps.push_back(mk(8'hFF, rb(1), z, z, z, z, z, z, 1, 8'hFF));
        steps.push_back(mk(8'hFF, rb(2), z, z, z, z, z, z, 2, 8'hFF));
        steps.push_back(mk(8'hFF, rb(3), z, z, z, z, z, z, 3, 8'hFF));
        steps.push_back(mk(8'hFF, rb(4), z, z, z, z, z, z, 4, 8'hFF));
        steps.push_back(mk(8'h02, rb(5), z, z, z, z, z, z, 5, 8'h02));
        steps.push_back(mk(8'h02, rb(6), z, z, z, z, z, z, 6, 8'h02));
        steps.push_back(mk(8'h02, rb(7), z, z, z, z, z, z, 7, 8'h02));
        steps.push_back(mk(8'h02, rb(8), z, z, z, z, z, z, 8, 8'h02));
        steps.push_back(mk(8'h00, z, rb(1)|rb(5), z, z, z, z, z, 1, 8'hFF));
        steps.push_back(mk(8'h00, z, rb(2)|rb(6), z, z, rb(1), z, z, 1, 8'hFE));
        steps.push_back(mk(8'h00, z, rb(3)|rb(7), z, z, rb(2), z, z, 2, 8'hFE));
        steps.push_back(mk(8'h00, z, rb(4)|rb(8), z, z, rb(3), z, z, 3, 8'hFE));
        steps.push_back(mk(8'h00, z, z, z, z, rb(4), z, z, 4, 8'hFE));
        // Adder wrap with overlapping enable in the read cycle.
        steps.push_back(mk(8'h03, rb(9)|rb(10), z, z, z, z, z, z, 10, 8'h03));
        steps.push_back(mk(8'h00, z, z, rb(9)|rb(1), z, z, z, z, 9, 8'h03));
        steps.push_back(mk(8'h00, z, z, rb(10)|rb(2), z, z, rb(1), z, 1, 8'h01));
        steps.push_back(mk(8'h00, z, z, z, z, z, rb(2), z, 2, 8'h01));
        // ADD2 result visible on f after one edge, then written back.
        steps.push_back(mk(8'h00, z, z, z, rb(1)|rb(5), z, z, z, 11, 8'h03));
        steps.push_back(mk(8'h00, z, z, z, z, z, z, rb(3), 3, 8'h03));
        // Write priority: load > mul_read > add1_read > add2_read.
        steps.push_back(mk(8'hAA, rb(1), z, z, z, rb(1), rb(1), z, 1, 8'hAA));
        steps.push_back(mk(8'h00, z, z, z, z, rb(2), rb(2), z, 2, 8'hFE));
        steps.push_back(mk(8'h00, z, z, z, z, z, rb(4), rb(4)|rb(6), 4, 8'h01));
        steps.push_back(mk(8'h00, z, z, z, z, z, z, z, 6, 8'h03));
        // Third enable bit ignored: AA*FE keeps low byte AC.
        steps.push_back(mk(8'h00, z, rb(1)|rb(2)|rb(4), z, z, z, z, z, 4, 8'h01));
        steps.push_back(mk(8'h00, z, z, z, z, rb(8), z, z, 8, 8'hAC));
        // Single enable bit leaves the unit idle; result holds.
        steps.push_back(mk(8'h00, z, rb(9), z, z, z, z, z, 9, 8'h03));
        steps.push_back(mk(8'h00, z, z, z, z, rb(7), z, z, 7, 8'hAC));
        steps.push_back(mk(8'h00, z, z, z, z, z, z, z, 11, 8'h03));

        reset = 1'b1;
        state = 4'd0; next_in = '0; load = '0;
        mul_en = '0; add1_en = '0; add2_en = '0;
        mul_read = '0; add1_read = '0; add2_read = '0;
        #12;
        for (int k = 1; k <= 11; k++) check({"reset_", obs_name(k)}, obs(k), 8'h00);
        @(negedge clk);
        reset = 1'b0;

        foreach (steps[i]) begin
            drive(steps[i].ni, steps[i].ld, steps[i].me, steps[i].a1e, steps[i].a2e,
                  steps[i].mr, steps[i].a1r, steps[i].a2r);
            check($sformatf("step%0d_%s", i, obs_name(steps[i].chk)), obs(steps[i].chk), steps[i].exp);
        end

        // Mid-run reset must clear everything before any clock edge.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        for (int k = 1; k <= 11; k++) check({"midreset_", obs_name(k)}, obs(k), 8'h00);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 1; i <= 10; i++) m_r[i] = 0;
        m_mul = 0; m_add1 = 0; m_add2 = 0;

        for (int c = 0; c < 300; c++) begin
            logic [7:0] ni;
            logic [9:0] ld, me, a1e, a2e, mr, a1r, a2r;
            ni  = 8'($urandom);
            ld  = rnd_sparse();
            me  = rnd_en();
            a1e = rnd_en();
            a2e = rnd_en();
            mr  = rnd_sparse();
            a1r = rnd_sparse();
            a2r = rnd_sparse();
            drive(ni, ld, me, a1e, a2e, mr, a1r, a2r);
            model_step(ni, ld, me, a1e, a2e, mr, a1r, a2r);
            for (int k = 1; k <= 10; k++)
                check($sformatf("rand%0d_%s", c, obs_name(k)), obs(k), 8'(m_r[k]));
            check($sformatf("rand%0d_f", c), f, 8'(m_add2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vector_datapath.md
Name: vector_datapath

Overview:
- Register-file datapath for the vector dot-product engine: ten 8-bit registers R1..R10, one multiplier unit (MUL) and two adder units (ADD1, ADD2).
- The external controller drives the per-register one-hot/multi-hot control vectors each cycle; the datapath has no internal sequencing.
- Operands enter from the input stream (next_in) or from unit write-back.
- All register contents are exposed for debug; f carries the ADD2 result.

Parameters:
- W, 8, data width of registers, operands and results.
- N, 10, number of registers; bit i-1 of each control vector addresses Ri.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- state  in  4  controller state code; informational only, does not affect datapath behaviour.
- next_in  in  8  input stream byte.
- load  in  10  Ri <= next_in where bit set.
- mul_en  in  10  selects the MUL operand pair.
- add1_en  in  10  selects the ADD1 operand pair.
- add2_en  in  10  selects the ADD2 operand pair.
- mul_read  in  10  Ri <= MUL result where bit set.
- add1_read  in  10  Ri <= ADD1 result where bit set.
- add2_read  in  10  Ri <= ADD2 result where bit set.
- r1..r10  out  8 each  current register contents, debug.
- f  out  8  ADD2 result register.

Behaviour:
- Reset (asynchronous, active-high):
  - R1..R10 clear to 0.
  - MUL, ADD1 and ADD2 result registers clear to 0; therefore f = 0.
  - Reset asserted mid-operation discards all in-flight results.
- Operand pair selection, per unit:
  - Operand A = the register at the lowest set bit of its _en vector; operand B = the register at the next set bit.
  - Bits beyond the second set bit are ignored.
  - Fewer than two bits set: the unit is idle and its result register holds its value.
- Unit timing (one-cycle latency):
  - At a rising edge where the unit has a valid pair, its result register captures the result computed from the pre-edge register values.
  - MUL result = low 8 bits of A*B (truncated).
  - ADDx result = (A+B) mod 256 (wraps; no carry out).
- Write-back:
  - At a rising edge, every Ri whose bit is set in mul_read, add1_read or add2_read takes the corresponding result register's pre-edge value.
  - A result is therefore written back one cycle after its _en cycle.
  - One result may be written to several registers at once.
- Write priority per register, same edge: load > mul_read > add1_read > add2_read.
  - No bit set in any write vector: Ri holds its value.
- Reads always see pre-edge values, so a register may be an operand and a write destination in the same cycle.
- r1..r10 and f are direct register outputs; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package: W, N, and the 4-bit state codes:
  - s1=0000, s2=0001, s3=0011, s4=0010, s5=0110, s6=0111
  - s7=1111, s8=1110, s9=1010, s10=1011, s11=1001, s12=1000
- One sub-module, pair_select: takes a 10-bit enable vector and the 10 registers; returns operand A, operand B and a valid flag. It is instantiated three times.

Test Plan:
- Reset then idle: assert reset mid-run -> all r1..r10 and f read 0 immediately, before any clock edge.
- Load: load bits 1..4 with next_in=FF over four cycles, then bits 5..8 with 02 -> r1..r4=FF, r5..r8=02.
- Multiply with write-back and truncation:
  - mul_en={R1,R5} for one cycle, then mul_read=R1 -> r1=FE after the second edge.
  - Repeat for pairs R2/R6 through R4/R8 in successive cycles; results are pipelined one cycle -> r2..r4=FE.
- Add wrap: r9=03, r1=FE; add1_en={R9,R1}, then add1_read=R1 -> r1=01. Overlapping add1_en {R10,R2} in the read cycle -> r2=01 one cycle later.
- ADD2 and f: add2_en={R1,R5} with r1=01, r5=02 -> f=03 after one edge; add2_read=R3 on the next edge -> r3=03.
- Write priority: same edge load=R1 (next_in=AA), mul_read=R1, add1_read=R1 -> r1=AA. Then mul_read and add1_read both on R2 -> r2=MUL result.
